b_mask_allocator: RTL
=====================

// Module: b_mask_allocator
// PURPOSE
//  Owns branch-stack slot allocation: grants B-mask tags to up to N branches dispatched per
//  cycle, tracks each slot's dependency mask, frees tags on correct resolve, squashes dependents
//  on mispredict. Sits between dispatch and branchstack; drives branchstack's next_b_mask.
// PARAMETERS
//  N             3  dispatch width (max branch grants per cycle)
//  B_MASK_WIDTH  4  branch-stack depth = tag count (`B_MASK_WIDTH)
// PORTS
//  clock           in   1                   system clock, rising edge
//  reset           in   1                   asynchronous, active-low reset
//  br_req_count    in   $clog2(N+1)         branches in dispatch bundle, program order
//  br_grant_count  out  $clog2(N+1)         prefix of requesters granted this cycle
//  br_grant_bmm    out  N x B_MASK_WIDTH    one-hot tag per grant; 0 when not granted
//  br_grant_dep    out  N x B_MASK_WIDTH    b_m to store with granted branch (older live tags)
//  br_stall        out  1                   br_req_count > br_grant_count
//  resolve_valid   in   1                   branch completing this cycle
//  resolve_bmm     in   B_MASK_WIDTH        one-hot tag of resolving branch
//  resolve_mispred in   1                   resolving branch mispredicted
//  b_mask          out  B_MASK_WIDTH        registered set of live tags (-> next_b_mask)
//  free_slots      out  $clog2(B_MASK_WIDTH+1)  popcount(~b_mask), registered
//  recovering      out  1                   FSM in RECOVER
// BEHAVIOUR
//  Reset (async, reset==0): b_mask=0, dep[*]=0, state=RUN, free_slots=B_MASK_WIDTH; all grant
//   outputs 0, br_stall=0, recovering=0. Release mid-dispatch grants nothing that cycle's edge.
//  State: live mask b_mask[W]; dep[s][W] = tags slot s depends on; FSM {RUN, RECOVER}.
//  Grant (combinational, RUN only): free = ~b_mask (start-of-cycle; slots freed this cycle
//   reusable next cycle only). grant_count = min(br_req_count, popcount(free)); grant k takes
//   k-th lowest-index free bit. br_grant_dep[k] = (b_mask & ~resolved_col) | bmm[0..k-1].
//  Correct resolve (valid & ~mispred & b_mask[r]): next cycle b_mask[r]=0, dep[*][r]=0, dep[r]=0.
//  Mispredict (valid & mispred & b_mask[r]): squash set S = {r} U {s : dep[s][r]}; next cycle
//   b_mask[S]=0, dep[S]=0, column r cleared; grant_count forced 0 this cycle (wrong path);
//   FSM RUN->RECOVER.
//  RECOVER: lasts exactly 1 cycle; grant_count=0, br_stall=(br_req_count!=0); ->RUN.
//   Mispredict arriving in RECOVER is processed identically (stays RECOVER one more cycle).
//  Resolve of non-live tag (b_mask[r]==0) or resolve_bmm==0: no state change, no FSM change.
//  Simultaneous grant + correct resolve: both apply; new dep excludes resolving tag.
//  Full (b_mask all 1s): grant_count=0, br_stall=(br_req_count!=0).
//  Outputs b_mask/free_slots/recovering registered; grant outputs combinational, 0-cycle latency.
//  Update order per edge: clear (resolve/squash) then set granted bits; disjoint by construction.
// STRUCTURE
//  sys_defs.svh: B_MASK, B_MASK_MASK typedefs, `B_MASK_WIDTH, `N; new enum BMA_STATE {RUN,RECOVER}.
//  Sub-module psel_lowest_n: one-hot selection of N lowest set bits of a W-bit vector.
//  Top holds dep matrix, b_mask, FSM, squash-set reduction.
// TESTING
//  1 reset, req=3 -> grant_count=3, bmm=0001/0010/0100, dep=0000/0001/0011; next b_mask=0111.
//  2 b_mask=0111, req=2 -> grant_count=1, bmm[0]=1000, br_stall=1; next b_mask=1111, free_slots=0.
//  3 b_mask=1111 chain 0<1<2<3, mispred tag 0010 -> grant 0, next b_mask=0001, recovering=1,
//    following cycle grants again from slot 1.
//  4 b_mask=0011, correct resolve 0001 with req=1 -> bmm=0100, dep=0010; next b_mask=0110,
//    dep[2]=0010, dep[1]=0000.
//  5 resolve of non-live tag 1000 with b_mask=0011 -> b_mask unchanged, state RUN.
//  6 reset asserted while b_mask=1011 and RECOVER -> immediately b_mask=0, free_slots=4, RUN.

Source files
------------

// File: rtl/b_mask_allocator_pkg.sv
// ----------------------------------------------------------------------------
// b_mask_allocator_pkg
//   Shared sizing, state encoding and helpers for the branch-mask allocator.
//   BMA_N   : dispatch width (max branch grants per cycle)
//   BMA_W   : branch-stack depth = number of B-mask tags
//   CNT_W   : width of request/grant counts (0..BMA_N)
//   FREE_W  : width of the free-slot count (0..BMA_W)
// ----------------------------------------------------------------------------
package b_mask_allocator_pkg;

  localparam int BMA_N  = 3;
  localparam int BMA_W  = 4;
  localparam int CNT_W  = $clog2(BMA_N + 1);
  localparam int FREE_W = $clog2(BMA_W + 1);

  typedef logic [BMA_W-1:0] b_mask_t;

  typedef enum logic {
    BMA_RUN     = 1'b0,
    BMA_RECOVER = 1'b1
  } bma_state_e;

  // Number of set bits in a tag vector.
  function automatic logic [FREE_W-1:0] popcount(input logic [BMA_W-1:0] vec);
    logic [FREE_W-1:0] cnt;
    cnt = {FREE_W{1'b0}};
    for (int i = 0; i < BMA_W; i++) begin
      cnt = cnt + {{(FREE_W-1){1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/b_mask_allocator_psel_lowest_n.sv
// ----------------------------------------------------------------------------
// b_mask_allocator_psel_lowest_n
//   Picks the N lowest-index set bits of a W-bit vector, one-hot per lane.
//   Lane 0 gets the lowest set bit, lane 1 the next, and so on; a lane with
//   no remaining set bit outputs all zeros.
//   vec : candidate bits (free tags)
//   sel : N one-hot selections, lowest index first
// ----------------------------------------------------------------------------
module b_mask_allocator_psel_lowest_n #(
  parameter int W = 4,
  parameter int N = 3
) (
  input  logic [W-1:0]        vec,
  output logic [N-1:0][W-1:0] sel
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Peel off the lowest set bit once per lane (x & -x isolates it).
  always_comb begin
    logic [W-1:0] rem;
    rem = vec;
    for (int k = 0; k < N; k++) begin
      sel[k] = rem & (~rem + ONE);
      rem    = rem & ~sel[k];
    end
  end

endmodule

// File: rtl/b_mask_allocator.sv
// ----------------------------------------------------------------------------
// b_mask_allocator
//   Branch-stack tag allocator. Grants one-hot B-mask tags to up to BMA_N
//   branches per dispatch bundle, records for each live slot the set of older
//   live tags it depends on, frees a tag on correct resolve and squashes the
//   mispredicted branch plus every dependent on mispredict.
//
//   clock            rising-edge clock
//   reset            asynchronous, active-low reset
//   br_req_count     branches in the dispatch bundle (program order)
//   br_grant_count   prefix of requesters granted this cycle (combinational)
//   br_grant_bmm     one-hot tag per granted lane, 0 otherwise (combinational)
//   br_grant_dep     dependency mask to store with each granted branch
//   br_stall         bundle not fully granted
//   resolve_valid    a branch resolves this cycle
//   resolve_bmm      one-hot tag of the resolving branch
//   resolve_mispred  resolving branch mispredicted
//   b_mask           registered set of live tags
//   free_slots       registered count of free tags
//   recovering       registered, high during the one-cycle recovery state
// ----------------------------------------------------------------------------
module b_mask_allocator
  import b_mask_allocator_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic [CNT_W-1:0]            br_req_count,
  output logic [CNT_W-1:0]            br_grant_count,
  output logic [BMA_N-1:0][BMA_W-1:0] br_grant_bmm,
  output logic [BMA_N-1:0][BMA_W-1:0] br_grant_dep,
  output logic                        br_stall,
  input  logic                        resolve_valid,
  input  logic [BMA_W-1:0]            resolve_bmm,
  input  logic                        resolve_mispred,
  output logic [BMA_W-1:0]            b_mask,
  output logic [FREE_W-1:0]           free_slots,
  output logic                        recovering
);

  // Registered state
  b_mask_t                 b_mask_q, b_mask_d;
  logic [BMA_W-1:0][BMA_W-1:0] dep_q, dep_d;
  bma_state_e              state_q, state_d;
  logic [FREE_W-1:0]       free_slots_q, free_slots_d;
  logic                    recovering_q;
  // Low for the first cycle after reset release so that cycle grants nothing.
  logic                    run_en_q;

  // Resolve decode
  b_mask_t res_hit_s;
  logic    res_live_s;
  logic    mispred_s;
  b_mask_t squash_s;
  b_mask_t clear_s;

  // Grant path
  b_mask_t                     free_s;
  logic [BMA_N-1:0][BMA_W-1:0] sel_s;
  logic                        grant_en_s;
  logic [FREE_W-1:0]           avail_s;
  logic [FREE_W-1:0]           req_ext_s;
  logic [CNT_W-1:0]            grant_count_s;
  logic [BMA_N-1:0][BMA_W-1:0] grant_bmm_s;
  logic [BMA_N-1:0][BMA_W-1:0] grant_dep_s;
  b_mask_t                     grant_set_s;
  b_mask_t                     older_s;
  logic                        stall_s;

  assign free_s = ~b_mask_q;

  b_mask_allocator_psel_lowest_n #(
    .W (BMA_W),
    .N (BMA_N)
  ) u_psel (
    .vec (free_s),
    .sel (sel_s)
  );

  // Decode the resolving tag and build the set of slots to clear.
  always_comb begin
    if (resolve_valid) begin
      res_hit_s = resolve_bmm & b_mask_q;
    end else begin
      res_hit_s = {BMA_W{1'b0}};
    end
    res_live_s = |res_hit_s;
    mispred_s  = res_live_s & resolve_mispred;
    // A slot is squashed if it is the mispredicted tag or depends on it.
    for (int s = 0; s < BMA_W; s++) begin
      squash_s[s] = res_hit_s[s] | (|(dep_q[s] & res_hit_s));
    end
    if (mispred_s) begin
      clear_s = squash_s;
    end else begin
      clear_s = res_hit_s;
    end
  end

  // Combinational grant: lowest free tags to the oldest requesters.
  always_comb begin
    b_mask_t acc;
    grant_en_s = reset & run_en_q & (state_q == BMA_RUN) & ~mispred_s;
    avail_s    = popcount(free_s);
    req_ext_s  = {{(FREE_W-CNT_W){1'b0}}, br_req_count};
    if (!grant_en_s) begin
      grant_count_s = {CNT_W{1'b0}};
    end else if (req_ext_s <= avail_s) begin
      grant_count_s = br_req_count;
    end else begin
      grant_count_s = avail_s[CNT_W-1:0];
    end
    // A correctly resolving tag is gone next cycle, so new branches must not depend on it.
    older_s = b_mask_q & ~res_hit_s;
    acc     = {BMA_W{1'b0}};
    for (int k = 0; k < BMA_N; k++) begin
      if (CNT_W'(k) < grant_count_s) begin
        grant_bmm_s[k] = sel_s[k];
        grant_dep_s[k] = older_s | acc;
      end else begin
        grant_bmm_s[k] = {BMA_W{1'b0}};
        grant_dep_s[k] = {BMA_W{1'b0}};
      end
      acc = acc | grant_bmm_s[k];
    end
    grant_set_s = acc;
    stall_s     = reset & (br_req_count > grant_count_s);
  end

  assign br_grant_count = grant_count_s;
  assign br_grant_bmm   = grant_bmm_s;
  assign br_grant_dep   = grant_dep_s;
  assign br_stall       = stall_s;

  // Next-state: clear resolved/squashed slots, then install new grants.
  always_comb begin
    b_mask_d = (b_mask_q & ~clear_s) | grant_set_s;
    for (int s = 0; s < BMA_W; s++) begin
      if (clear_s[s]) begin
        dep_d[s] = {BMA_W{1'b0}};
      end else begin
        dep_d[s] = dep_q[s] & ~clear_s;
      end
    end
    // Granted slots were free, so they never collide with cleared slots.
    for (int k = 0; k < BMA_N; k++) begin
      for (int s = 0; s < BMA_W; s++) begin
        dep_d[s] = grant_bmm_s[k][s] ? grant_dep_s[k] : dep_d[s];
      end
    end
    if (mispred_s) begin
      state_d = BMA_RECOVER;
    end else begin
      state_d = BMA_RUN;
    end
    free_slots_d = popcount(~b_mask_d);
  end

  // State registers and FSM with registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b_mask_q     <= {BMA_W{1'b0}};
      dep_q        <= {(BMA_W*BMA_W){1'b0}};
      state_q      <= BMA_RUN;
      free_slots_q <= FREE_W'(BMA_W);
      recovering_q <= 1'b0;
      run_en_q     <= 1'b0;
    end else begin
      b_mask_q     <= b_mask_d;
      dep_q        <= dep_d;
      state_q      <= state_d;
      free_slots_q <= free_slots_d;
      recovering_q <= (state_d == BMA_RECOVER);
      run_en_q     <= 1'b1;
    end
  end

  assign b_mask     = b_mask_q;
  assign free_slots = free_slots_q;
  assign recovering = recovering_q;

endmodule
